// File: rtl/random_range_pkg.sv
// rtl/random_range_pkg.sv - shared types and constants for bounded random sampling
package random_range_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MASK   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Try counter needs ceil(log2(n)) bits, kept at least 1 so MAX_TRIES=1 still synthesizes
  function automatic int try_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/range_mask.sv
// rtl/range_mask.sv - combinational MSB smear: every bit at and below the top set bit
module range_mask
  import random_range_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] mask
);

  always_comb begin
    mask = '0;
    mask[WIDTH-1] = in_val[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      mask[i] = mask[i+1] | in_val[i];
    end
  end

endmodule

// File: rtl/random_range.sv
// rtl/random_range.sv - rejection sampler turning a free-running LFSR into values in [0, bound)
module random_range
  import random_range_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] random,
  input  logic             req,
  input  logic [WIDTH-1:0] bound,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  input  logic             ack,
  output logic             fallback
);

  localparam int TW = try_width(MAX_TRIES);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bnd_q, bnd_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [TW-1:0]    try_q, try_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             fallback_q, fallback_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] bnd_m1;
  logic [WIDTH-1:0] smear;
  logic [WIDTH-1:0] masked;
  logic             accept;
  logic             last_try;

  // bnd=0 wraps to all ones, which yields the full-range mask
  assign bnd_m1 = bnd_q - WIDTH'(1);

  range_mask #(.WIDTH(WIDTH)) u_range_mask (
    .in_val (bnd_m1),
    .mask   (smear)
  );

  assign masked   = random & mask_q;
  assign accept   = (bnd_q == '0) || (masked < bnd_q);
  assign last_try = (try_q == TW'(MAX_TRIES - 1));

  always_comb begin
    state_d    = state_q;
    bnd_d      = bnd_q;
    mask_d     = mask_q;
    try_d      = try_q;
    value_d    = value_q;
    valid_d    = valid_q;
    fallback_d = fallback_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          bnd_d   = bound;
          state_d = MASK;
        end
      end
      MASK: begin
        mask_d  = smear;
        try_d   = '0;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (accept) begin
          value_d    = masked;
          fallback_d = 1'b0;
          valid_d    = 1'b1;
          state_d    = DONE;
        end else if (last_try) begin
          // masked < 2*bnd here, so the difference still lands in range
          value_d    = masked - bnd_q;
          fallback_d = 1'b1;
          valid_d    = 1'b1;
          state_d    = DONE;
        end else begin
          try_d = try_q + TW'(1);
        end
      end
      DONE: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bnd_q      <= '0;
      mask_q     <= '0;
      try_q      <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      bnd_q      <= bnd_d;
      mask_q     <= mask_d;
      try_q      <= try_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
      ready_q    <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign value    = value_q;
  assign fallback = fallback_q;

endmodule

// File: tb/tb_random_range.sv
// tb/tb_random_range.sv - self-checking bench for random_range against an arithmetic model
module tb_random_range;

  localparam int W  = 16;
  localparam int MT = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] random;
  logic         req;
  logic [W-1:0] bound;
  logic         ready;
  logic         valid;
  logic [W-1:0] value;
  logic         ack;
  logic         fallback;

  int n_cmp;
  int n_bad;

  logic [W-1:0] words [MT];

  random_range #(.WIDTH(W), .MAX_TRIES(MT)) dut (
    .clk      (clk),
    .rst      (rst),
    .random   (random),
    .req      (req),
    .bound    (bound),
    .ready    (ready),
    .valid    (valid),
    .value    (value),
    .ack      (ack),
    .fallback (fallback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Smallest power of two >= bound, minus one, picks the mask; then scan the sample words.
  task automatic model(input logic [W-1:0] b, output logic [W-1:0] v, output logic fb, output int k);
    int p;
    int mask;
    int m;
    if (b == 0) mask = 'hFFFF;
    else begin
      p = 1;
      while (p < int'(b)) p = p * 2;
      mask = p - 1;
    end
    fb = 1'b0;
    v  = '0;
    k  = MT - 1;
    for (int i = 0; i < MT; i++) begin
      m = int'(words[i]) & mask;
      if (b == 0 || m < int'(b)) begin
        v = W'(m);
        k = i;
        return;
      end
    end
    m  = int'(words[MT-1]) & mask;
    v  = W'(m - int'(b));
    fb = 1'b1;
  endtask

  // Issue a request, feed words[] on the sample edges, check value/fallback/latency; leaves DONE.
  task automatic issue(input logic [W-1:0] b, input string name, output logic got);
    logic [W-1:0] ev;
    logic         efb;
    int           ek;
    int           seen;
    model(b, ev, efb, ek);
    got = 1'b0;
    @(negedge clk);
    req = 1'b1; bound = b; random = W'($urandom);
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL %s accept: ready=%b want 0", name, ready);
    end
    req = 1'b0; bound = W'($urandom); random = W'($urandom);
    @(negedge clk);
    random = words[0];
    seen = -1;
    for (int i = 0; i < MT; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        seen = i;
        break;
      end
      if (i + 1 < MT) random = words[i+1];
    end
    random = W'($urandom);
    n_cmp++;
    if (seen != ek) begin
      n_bad++; $display("FAIL %s latency: sample=%0d want %0d", name, seen, ek);
    end
    if (seen >= 0) begin
      got = 1'b1;
      n_cmp++;
      if (value !== ev || fallback !== efb) begin
        n_bad++;
        $display("FAIL %s value: value=%h fb=%b want %h fb=%b", name, value, fallback, ev, efb);
      end
    end
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ack: valid=%b ready=%b want 0 1", name, valid, ready);
    end
  endtask

  task automatic run_one(input logic [W-1:0] b, input string name);
    logic got;
    issue(b, name, got);
    if (got) do_ack(name);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; ack = 1'b0; bound = '0; random = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || valid !== 1'b0 || value !== '0 || fallback !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: ready=%b valid=%b value=%h fb=%b want 1 0 0 0", ready, valid, value, fallback);
    end
    // Mid-SAMPLE reset, off the clock edge
    for (int i = 0; i < MT; i++) words[i] = 16'h000F;
    @(negedge clk);
    req = 1'b1; bound = 16'd10;
    @(negedge clk);
    req = 1'b0; random = 16'h000F;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || valid !== 1'b0 || value !== '0 || fallback !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: ready=%b valid=%b value=%h fb=%b want 1 0 0 0", ready, valid, value, fallback);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0 || ready !== 1'b1) begin
        n_bad++; $display("FAIL reset_drop: cycle %0d valid=%b ready=%b want 0 1", i, valid, ready);
      end
    end
  endtask

  task automatic test_directed;
    for (int i = 0; i < MT; i++) words[i] = W'($urandom);
    words[0] = 16'h0007;
    run_one(16'd10, "first_accept");
    for (int i = 0; i < MT; i++) words[i] = W'($urandom);
    words[0] = 16'h000C; words[1] = 16'h000E; words[2] = 16'h0023;
    run_one(16'd10, "two_rejects");
    for (int i = 0; i < MT; i++) words[i] = 16'h000F;
    run_one(16'd10, "fallback");
  endtask

  task automatic test_boundaries;
    for (int i = 0; i < MT; i++) words[i] = W'($urandom);
    words[0] = 16'hBEEF;
    run_one(16'd0, "bound0");
    words[0] = 16'hFFFF;
    run_one(16'd16, "bound16");
    run_one(16'd1, "bound1");
    words[0] = 16'hFFFF;
    run_one(16'h8000, "bound_pow2_top");
  endtask

  task automatic test_handshake;
    logic         got;
    logic [W-1:0] held_v;
    logic         held_fb;
    for (int i = 0; i < MT; i++) words[i] = W'($urandom);
    words[0] = 16'h0005;
    issue(16'd10, "hs", got);
    held_v  = value;
    held_fb = fallback;
    if (got) begin
      for (int i = 0; i < 5; i++) begin
        req = (i == 2); bound = W'($urandom);
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || ready !== 1'b0 || value !== held_v || fallback !== held_fb) begin
          n_bad++;
          $display("FAIL hs_hold: cycle %0d valid=%b ready=%b value=%h want 1 0 %h", i, valid, ready, value, held_v);
        end
      end
      req = 1'b0;
      do_ack("hs");
    end
    words[0] = 16'h0002;
    run_one(16'd3, "hs_next");
  endtask

  task automatic test_random;
    logic [W-1:0] b;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(1, 40));
        1: b = W'(1 << $urandom_range(0, 15));
        2: b = W'($urandom);
        default: b = W'($urandom_range(0, 2));
      endcase
      for (int i = 0; i < MT; i++) words[i] = W'($urandom);
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < MT; i++) words[i] = words[i] | 16'hFFF0;
      run_one(b, "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    req = 1'b0; ack = 1'b0; bound = '0; random = '0; rst = 1'b1;
    test_reset();
    test_directed();
    test_boundaries();
    test_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
